// File: rtl/cpu_wb_arbiter.sv
// rtl/cpu_wb_arbiter.sv - two-master pipelined Wishbone arbiter (instruction fetch + data port onto one slave)
// Optional build macro WB_ARB_RR_EN: round-robin tie-break in IDLE instead of fixed data priority.
module cpu_wb_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                i_cyc,
  input  logic                i_stb,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_ack,
  output logic                i_stall,
  output logic [DATA_W-1:0]   i_dat,
  input  logic                d_stb,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdat,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdat,
  output logic                m_cyc,
  output logic                m_stb,
  output logic                m_we,
  output logic [DATA_W/8-1:0] m_sel,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdat,
  input  logic [DATA_W-1:0]   m_rdat,
  input  logic                m_ack,
  input  logic                m_stall,
  output logic                spur_ack
);

  localparam int CNT_W = $clog2(MAX_OUTST) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] outst;
  logic [CNT_W-1:0] outst_nxt;
  logic             spur_q;
  logic             req_i;
  logic             req_d;
  logic             own_stb;
  logic             full;
  logic             outst_zero;
  logic             accept;
  logic             ack_ok;
  logic             ack_spur;
  logic             tie_to_d;

  assign req_i      = i_cyc & i_stb;
  assign req_d      = d_stb;
  assign outst_zero = (outst == '0);
  assign full       = (outst == CNT_MAX);
  assign m_stb      = own_stb & ~full;
  assign accept     = m_stb & ~m_stall;
  // An ack with nothing in flight is never forwarded; it only raises the sticky flag.
  assign ack_ok     = m_ack & ~outst_zero;
  assign ack_spur   = m_ack & outst_zero;

`ifdef WB_ARB_RR_EN
  logic last_d;

  // Remembers who was granted last so a tie goes to the other master.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      last_d <= 1'b0;
    end else if (state == IDLE && state_nxt == GNT_D) begin
      last_d <= 1'b1;
    end else if (state == IDLE && state_nxt == GNT_I) begin
      last_d <= 1'b0;
    end
  end

  assign tie_to_d = ~last_d;
`else
  assign tie_to_d = 1'b1;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state  <= IDLE;
      outst  <= '0;
      spur_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      outst  <= outst_nxt;
      if (ack_spur) begin
        spur_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    m_cyc     = 1'b0;
    own_stb   = 1'b0;
    m_we      = 1'b0;
    m_sel     = '0;
    m_addr    = '0;
    m_wdat    = '0;
    i_stall   = 1'b1;
    case (state)
      IDLE: begin
        if (req_d && req_i) begin
          state_nxt = tie_to_d ? GNT_D : GNT_I;
        end else if (req_d) begin
          state_nxt = GNT_D;
        end else if (req_i) begin
          state_nxt = GNT_I;
        end
      end
      GNT_I: begin
        m_cyc   = 1'b1;
        own_stb = req_i;
        m_sel   = '1;
        m_addr  = i_addr;
        i_stall = m_stall | full;
        // Hand back only once the fetch master has closed its cycle and every request is acked.
        if (!i_cyc && outst_zero) begin
          state_nxt = IDLE;
        end
      end
      GNT_D: begin
        m_cyc   = 1'b1;
        own_stb = req_d;
        m_we    = d_we;
        m_sel   = d_be;
        m_addr  = d_addr;
        m_wdat  = d_wdat;
        if (!d_stb && outst_zero) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_comb begin
    outst_nxt = outst;
    if (accept && !ack_ok) begin
      outst_nxt = outst + CNT_W'(1);
    end else if (ack_ok && !accept) begin
      outst_nxt = outst - CNT_W'(1);
    end
    if (state_nxt == IDLE) begin
      outst_nxt = '0;
    end
  end

  assign i_ack    = ack_ok & (state == GNT_I);
  assign d_ack    = ack_ok & (state == GNT_D);
  assign i_dat    = m_rdat;
  assign d_rdat   = m_rdat;
  assign spur_ack = spur_q;

endmodule
